camera_capture: RTL and testbench

CAMERA_CAPTURE -- requirements
Module: camera_capture

---
 rtl/camera_capture_if.sv | 25 ++
 rtl/camera_capture.sv | 115 +++++++++++
 tb/tb_camera_capture.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/camera_capture_if.sv
// Camera-side and pixel-side signal bundle for camera_capture.
// master = sensor/consumer side (bench), slave = capture core.
interface camera_capture_if;
  logic        CONFIG_FINISHED;
  logic        PCLK;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  D;
  logic [15:0] PIXEL_DATA;
  logic        PIXEL_VALID;
  logic [9:0]  PIXEL_X;
  logic [8:0]  PIXEL_Y;
  logic        FRAME_START;
  logic        FRAME_DONE;
  logic        OVERRUN;

  modport master (
    output CONFIG_FINISHED, PCLK, VSYNC, HREF, D,
    input  PIXEL_DATA, PIXEL_VALID, PIXEL_X, PIXEL_Y, FRAME_START, FRAME_DONE, OVERRUN
  );
  modport slave (
    input  CONFIG_FINISHED, PCLK, VSYNC, HREF, D,
    output PIXEL_DATA, PIXEL_VALID, PIXEL_X, PIXEL_Y, FRAME_START, FRAME_DONE, OVERRUN
  );
endinterface

// File: rtl/camera_capture.sv
// DVP camera capture: oversampled PCLK/VSYNC/HREF/D, RGB565 pixel assembly with X/Y.
// Optional macro CAPTURE_DECIMATE_EN: strobe only even-X/even-Y pixels at halved coordinates.
module camera_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input logic             GLOBAL_CLK,
  input logic             RESET,
  camera_capture_if.slave cam
);
  typedef enum logic [1:0] {IDLE, WAIT_VS_HIGH, WAIT_VS_LOW, CAPTURE} state_t;

  state_t      state;
  logic [2:0]  pclk_s, vs_s, href_s;
  logic [7:0]  d_s0, d_s1;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        phase;
  logic [7:0]  hi_byte;

  // Stage 1 of every pipe is the aligned "current" value, stage 2 the previous one.
  wire sample    = pclk_s[1] & ~pclk_s[2];
  wire vs_rise   = vs_s[1] & ~vs_s[2];
  wire vs_fall   = ~vs_s[1] & vs_s[2];
  wire href_fall = ~href_s[1] & href_s[2];
  wire x_ok      = x < 10'(H_ACTIVE);
  wire y_ok      = y < 9'(V_ACTIVE);

  always_ff @(posedge GLOBAL_CLK) begin
    if (!RESET) begin
      state           <= IDLE;
      pclk_s          <= '0;
      vs_s            <= '0;
      href_s          <= '0;
      d_s0            <= '0;
      d_s1            <= '0;
      x               <= '0;
      y               <= '0;
      phase           <= 1'b0;
      hi_byte         <= '0;
      cam.PIXEL_DATA  <= '0;
      cam.PIXEL_VALID <= 1'b0;
      cam.PIXEL_X     <= '0;
      cam.PIXEL_Y     <= '0;
      cam.FRAME_START <= 1'b0;
      cam.FRAME_DONE  <= 1'b0;
      cam.OVERRUN     <= 1'b0;
    end else begin
      pclk_s          <= {pclk_s[1:0], cam.PCLK};
      vs_s            <= {vs_s[1:0], cam.VSYNC};
      href_s          <= {href_s[1:0], cam.HREF};
      d_s0            <= cam.D;
      d_s1            <= d_s0;
      cam.PIXEL_VALID <= 1'b0;
      cam.FRAME_START <= 1'b0;
      cam.FRAME_DONE  <= 1'b0;

      // Losing configuration aborts silently; OVERRUN is deliberately kept.
      if (!cam.CONFIG_FINISHED) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:         state <= WAIT_VS_HIGH;
          WAIT_VS_HIGH: if (vs_s[1]) state <= WAIT_VS_LOW;
          WAIT_VS_LOW: if (vs_fall) begin
            state           <= CAPTURE;
            cam.FRAME_START <= 1'b1;
            x               <= '0;
            y               <= '0;
            phase           <= 1'b0;
          end
          CAPTURE: begin
            if (sample && href_s[1]) begin
              if (!phase) begin
                hi_byte <= d_s1;
                phase   <= 1'b1;
              end else begin
                phase <= 1'b0;
                if (x_ok && y_ok) begin
                  x <= x + 10'd1;
`ifdef CAPTURE_DECIMATE_EN
                  if (!x[0] && !y[0]) begin
                    cam.PIXEL_DATA  <= {hi_byte, d_s1};
                    cam.PIXEL_VALID <= 1'b1;
                    cam.PIXEL_X     <= {1'b0, x[9:1]};
                    cam.PIXEL_Y     <= {1'b0, y[8:1]};
                  end
`else
                  cam.PIXEL_DATA  <= {hi_byte, d_s1};
                  cam.PIXEL_VALID <= 1'b1;
                  cam.PIXEL_X     <= x;
                  cam.PIXEL_Y     <= y;
`endif
                end else begin
                  cam.OVERRUN <= 1'b1;
                end
              end
            end else if (href_fall) begin
              // A lone phase-0 byte at line end is dropped here.
              x     <= '0;
              phase <= 1'b0;
              if (y_ok) y <= y + 9'd1;
            end
            // Any pixel completing this cycle is strobed alongside FRAME_DONE.
            if (vs_rise) begin
              cam.FRAME_DONE <= 1'b1;
              state          <= WAIT_VS_LOW;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_camera_capture.sv
// Scoreboard bench for camera_capture: directed DVP frames, expected pixels queued ahead of the DUT.
module tb_camera_capture;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  camera_capture_if cif();

  camera_capture #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .GLOBAL_CLK(clk),
    .RESET(rst_n),
    .cam(cif.slave)
  );

  typedef struct {
    logic [15:0] d;
    logic [9:0]  x;
    logic [8:0]  y;
  } pix_t;

  pix_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   fs_cnt = 0;
  int   fd_cnt = 0;
  logic prev_pv = 1'b0, prev_fs = 1'b0, prev_fd = 1'b0;
  logic [7:0] hi0, lo0, step;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe, tracks frame pulses.
  always @(negedge clk) begin
    if (cif.PIXEL_VALID) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pixel_unexpected: got d=%h x=%0d y=%0d, expected no strobe",
                 cif.PIXEL_DATA, cif.PIXEL_X, cif.PIXEL_Y);
      end else begin
        pix_t e;
        e = sb.pop_front();
        if (cif.PIXEL_DATA !== e.d || cif.PIXEL_X !== e.x || cif.PIXEL_Y !== e.y) begin
          errors++;
          $display("FAIL pixel: got d=%h x=%0d y=%0d expected d=%h x=%0d y=%0d",
                   cif.PIXEL_DATA, cif.PIXEL_X, cif.PIXEL_Y, e.d, e.x, e.y);
        end
      end
    end
    if (cif.PIXEL_VALID || cif.FRAME_START || cif.FRAME_DONE) begin
      checks++;
      if ((cif.PIXEL_VALID && prev_pv) || (cif.FRAME_START && prev_fs) || (cif.FRAME_DONE && prev_fd)) begin
        errors++;
        $display("FAIL pulse_width: pv=%b fs=%b fd=%b high two cycles, expected single-cycle",
                 cif.PIXEL_VALID, cif.FRAME_START, cif.FRAME_DONE);
      end
    end
    if (cif.FRAME_START) fs_cnt++;
    if (cif.FRAME_DONE) begin
      fd_cnt++;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL frame_done_early: got %0d pixels outstanding, expected 0", sb.size());
      end
    end
    prev_pv = cif.PIXEL_VALID;
    prev_fs = cif.FRAME_START;
    prev_fd = cif.FRAME_DONE;
  end

  task automatic exp_pix(input logic [15:0] d, input int x, input int y);
    pix_t e;
`ifdef CAPTURE_DECIMATE_EN
    if (x % 2 == 0 && y % 2 == 0) begin
      e.d = d; e.x = 10'(x / 2); e.y = 9'(y / 2);
      sb.push_back(e);
    end
`else
    e.d = d; e.x = 10'(x); e.y = 9'(y);
    sb.push_back(e);
`endif
  endtask

  // One PCLK period = 8 GLOBAL_CLK cycles; inputs change with PCLK falling.
  task automatic pclk_cyc(input logic v, input logic h, input logic [7:0] d);
    @(negedge clk);
    cif.VSYNC = v; cif.HREF = h; cif.D = d; cif.PCLK = 1'b0;
    repeat (4) @(negedge clk);
    cif.PCLK = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic line(input int nbytes, input int l, input bit ex);
    logic [7:0] hi, lo;
    for (int k = 0; k < nbytes; k++) begin
      hi = 8'(hi0 + step * (k / 2));
      lo = 8'(lo0 + step * l);
      if (k % 2 == 0) pclk_cyc(1'b0, 1'b1, hi);
      else begin
        if (ex && (k / 2) < 640) exp_pix({hi, lo}, k / 2, l);
        pclk_cyc(1'b0, 1'b1, lo);
      end
    end
    repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_open();
    repeat (3) pclk_cyc(1'b1, 1'b0, 8'h00);
    pclk_cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame_close();
    repeat (2) pclk_cyc(1'b1, 1'b0, 8'h00);
  endtask

  task automatic frame(input int nl, input int nb, input bit ex);
    frame_open();
    for (int l = 0; l < nl; l++) line(nb, l, ex);
    frame_close();
  endtask

  initial begin
    int fs0, fd0;
    cif.CONFIG_FINISHED = 1'b0;
    cif.PCLK = 1'b0; cif.VSYNC = 1'b0; cif.HREF = 1'b0; cif.D = 8'h00;
    hi0 = 8'hF8; lo0 = 8'h00; step = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", cif.PIXEL_VALID, 0);
    chk("rst_data", cif.PIXEL_DATA, 0);
    chk("rst_x", cif.PIXEL_X, 0);
    chk("rst_y", cif.PIXEL_Y, 0);
    chk("rst_fs", cif.FRAME_START, 0);
    chk("rst_fd", cif.FRAME_DONE, 0);
    chk("rst_overrun", cif.OVERRUN, 0);
    rst_n = 1'b1;

    // Not configured: two frames ignored
    frame(4, 8, 1'b0);
    frame(4, 8, 1'b0);
    chk("nocfg_fs", fs_cnt, 0);
    chk("nocfg_fd", fd_cnt, 0);

    // 4x4 frame of 0xF800
    @(negedge clk); cif.CONFIG_FINISHED = 1'b1;
    fs0 = fs_cnt; fd0 = fd_cnt;
    frame(4, 8, 1'b1);
    chk("f44_fs", fs_cnt - fs0, 1);
    chk("f44_fd", fd_cnt - fd0, 1);
    chk("f44_drain", sb.size(), 0);

    // Odd-length line: 5th byte dropped, next line at X=0, Y+1
    hi0 = 8'h12; lo0 = 8'h34; step = 8'h03;
    frame_open();
    line(5, 0, 1'b1);
    line(4, 1, 1'b1);
    frame_close();
    chk("odd_drain", sb.size(), 0);

    // Enable arrives mid-frame: that frame ignored, next one from (0,0)
    @(negedge clk); cif.CONFIG_FINISHED = 1'b0;
    fs0 = fs_cnt; fd0 = fd_cnt;
    frame_open();
    line(8, 0, 1'b0);
    @(negedge clk); cif.CONFIG_FINISHED = 1'b1;
    line(8, 1, 1'b0);
    line(8, 2, 1'b0);
    frame_close();
    chk("mid_fs", fs_cnt - fs0, 0);
    chk("mid_fd", fd_cnt - fd0, 0);
    hi0 = 8'hA0; lo0 = 8'h05; step = 8'h11;
    frame(2, 6, 1'b1);
    chk("mid_next_fs", fs_cnt - fs0, 1);

    // Config drop mid-capture: no FRAME_DONE
    fs0 = fs_cnt; fd0 = fd_cnt;
    frame_open();
    line(8, 0, 1'b1);
    @(negedge clk); cif.CONFIG_FINISHED = 1'b0;
    line(8, 1, 1'b0);
    frame_close();
    chk("drop_fs", fs_cnt - fs0, 1);
    chk("drop_fd", fd_cnt - fd0, 0);
    @(negedge clk); cif.CONFIG_FINISHED = 1'b1;

    // 8x4 frame (decimated to 4x2 when the option is built in)
    hi0 = 8'h40; lo0 = 8'h80; step = 8'h07;
    frame(4, 16, 1'b1);
    chk("f84_drain", sb.size(), 0);
    chk("f84_overrun", cif.OVERRUN, 0);

    // 642-pixel line: 640 strobes, OVERRUN sticky
    hi0 = 8'h00; lo0 = 8'h5A; step = 8'h01;
    frame(1, 642 * 2, 1'b1);
    chk("ovr_set", cif.OVERRUN, 1);
    frame(2, 4, 1'b1);
    chk("ovr_sticky", cif.OVERRUN, 1);

    // Reset mid-line after a phase-0 byte: no partial pixel, wait for next frame
    frame_open();
    pclk_cyc(1'b0, 1'b1, 8'hEE);
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_overrun", cif.OVERRUN, 0);
    chk("mrst_valid", cif.PIXEL_VALID, 0);
    rst_n = 1'b1;
    pclk_cyc(1'b0, 1'b1, 8'h11);
    repeat (2) pclk_cyc(1'b0, 1'b0, 8'h00);
    line(8, 1, 1'b0);
    frame_close();
    fs0 = fs_cnt;
    hi0 = 8'h3C; lo0 = 8'hC3; step = 8'h02;
    frame(2, 8, 1'b1);
    chk("mrst_next_fs", fs_cnt - fs0, 1);

    repeat (20) @(negedge clk);
    chk("final_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
